jk_bank_arbiter: RTL and testbench

- Shares one bank of NBITS JK flip-flop cells between NREQ requesters.
- Each requester issues single-cycle JK commands (hold/clear/set/toggle) aimed at one cell index.
- Round-robin arbitration accepts at most one command per cycle.
- An optional lock gives one requester exclusive bank ownership for multi-beat sequences; a timeout protects the bank from a stalled owner.

---
 rtl/jk_arb_pkg.sv | 18 +
 rtl/jk_cell_bank.sv | 40 ++++
 rtl/jk_bank_arbiter.sv | 159 +++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared JK op encodings, arbiter FSM states and a clog2 helper for the JK bank arbiter.
package jk_arb_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  typedef enum logic {ST_IDLE, ST_OWNED} arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/jk_cell_bank.sv
// Bank of NBITS JK cells sharing one j/k command; only enabled cells react.
module jk_cell_bank
  import jk_arb_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] cell_en,
  input  logic             j,
  input  logic             k,
  output logic [NBITS-1:0] q,
  output logic [NBITS-1:0] qb
);

  logic [NBITS-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < NBITS; b++) begin
      if (cell_en[b]) begin
        case ({j, k})
          JK_CLR:  q_d[b] = 1'b0;
          JK_SET:  q_d[b] = 1'b1;
          JK_TOG:  q_d[b] = ~q_q[b];
          default: q_d[b] = q_q[b];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a JK cell bank, with lock ownership and idle timeout.
// Define JK_ARB_ERR_EN to flag out-of-range cell indices on the sticky err output.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int NBITS        = 8,
  parameter  int LOCK_TIMEOUT = 15,
  localparam int IDXW         = (NBITS > 1) ? clog2(NBITS) : 1,
  localparam int RW           = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*2-1:0]    req_jk,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     qb,
  output logic [RW-1:0]        grant_id,
  output logic                 locked,
  output logic                 err
);

  localparam int TW = clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [RW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]    owner_q, owner_d;
  logic [RW-1:0]    grant_id_q, grant_id_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;

  logic             arb_found;
  logic [RW-1:0]    arb_id;
  logic             sel_valid;
  logic [RW-1:0]    sel_id;
  logic [IDXW-1:0]  sel_idx;
  logic [1:0]       sel_jk;
  logic             sel_lock;
  logic             accept;
  logic [NBITS-1:0] cell_en;

  function automatic logic [RW-1:0] next_ptr(input logic [RW-1:0] id);
    return RW'((int'(id) + 1) % NREQ);
  endfunction

  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_id    = '0;
    for (int n = 0; n < NREQ; n++) begin
      cand = (int'(rr_ptr_q) + n) % NREQ;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_id    = RW'(cand);
      end
    end
  end

  // While owned, the owner is the only candidate regardless of rr_ptr.
  always_comb begin
    sel_id    = (state_q == ST_OWNED) ? owner_q : arb_id;
    sel_valid = (state_q == ST_OWNED) ? req_valid[owner_q] : arb_found;
    accept    = sel_valid && !rst;
    sel_idx   = req_idx[int'(sel_id)*IDXW +: IDXW];
    sel_jk    = req_jk[int'(sel_id)*2 +: 2];
    sel_lock  = req_lock[sel_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_id_q <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_id_q <= grant_id_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_id_d = grant_id_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rr_ptr_d   = next_ptr(sel_id);
          grant_id_d = sel_id;
          tmo_d      = '0;
          if (sel_lock) begin
            state_d = ST_OWNED;
            owner_d = sel_id;
          end
        end
      end
      ST_OWNED: begin
        if (accept) begin
          grant_id_d = sel_id;
          tmo_d      = '0;
          if (!sel_lock) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr(owner_q);
          end
        end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr(owner_q);
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef JK_ARB_ERR_EN
    if (accept && (int'(sel_idx) >= NBITS)) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  // An out-of-range index matches no cell, so such a beat is acked but changes nothing.
  always_comb begin
    req_ready = '0;
    cell_en   = '0;
    if (accept) begin
      req_ready[sel_id] = 1'b1;
      for (int b = 0; b < NBITS; b++) cell_en[b] = (int'(sel_idx) == b);
    end
  end

  jk_cell_bank #(.NBITS(NBITS)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .cell_en (cell_en),
    .j       (sel_jk[1]),
    .k       (sel_jk[0]),
    .q       (q),
    .qb      (qb)
  );

  assign grant_id = grant_id_q;
  assign locked   = (state_q == ST_OWNED);
  assign err      = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: vector table, directed lock sequences,
// random traffic against a behavioural model, and a 6-cell instance for the range error.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_lock;
  logic [11:0] req_idx;
  logic [7:0]  req_jk;
  logic [7:0]  q, qb;
  logic [1:0]  grant_id;
  logic        locked, err;

  logic [3:0]  d6_valid, d6_ready, d6_lock;
  logic [11:0] d6_idx;
  logic [7:0]  d6_jk;
  logic [5:0]  d6_q, d6_qb;
  logic [1:0]  d6_gid;
  logic        d6_locked, d6_err;

`ifdef JK_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_jk(req_jk), .req_lock(req_lock),
    .q(q), .qb(qb), .grant_id(grant_id), .locked(locked), .err(err)
  );

  jk_bank_arbiter #(.NBITS(6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(d6_valid), .req_ready(d6_ready),
    .req_idx(d6_idx), .req_jk(d6_jk), .req_lock(d6_lock),
    .q(d6_q), .qb(d6_qb), .grant_id(d6_gid), .locked(d6_locked), .err(d6_err)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [11:0] idx;
    logic [7:0]  jk;
    logic [3:0]  lock;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_q;
    logic [1:0]  exp_gid;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[13];

  // Behavioural model: bank contents, round-robin start, current owner (-1 = none).
  logic [7:0] m_q;
  int m_rr, m_owner, m_idle, m_gid;

  logic       p_v[4];
  logic [2:0] p_idx[4];
  logic [1:0] p_jk[4];
  logic       p_lk[4];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [11:0] ix,
                              input logic [7:0] jk, input logic [3:0] er, input logic [7:0] eq,
                              input logic [1:0] eg, input logic el);
    vec_t t;
    t.rst = r; t.valid = v; t.idx = ix; t.jk = jk; t.lock = 4'b0000;
    t.exp_ready = er; t.exp_q = eq; t.exp_gid = eg; t.exp_locked = el;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    rst       = t.rst;
    req_valid = t.valid;
    req_idx   = t.idx;
    req_jk    = t.jk;
    req_lock  = t.lock;
  endtask

  task automatic setReq(input int i, input logic v, input logic [2:0] ix, input logic [1:0] jk, input logic lk);
    req_valid[i]       = v;
    req_idx[i*3 +: 3]  = ix;
    req_jk[i*2 +: 2]   = jk;
    req_lock[i]        = lk;
  endtask

  task automatic clearReqs();
    req_valid = '0; req_idx = '0; req_jk = '0; req_lock = '0;
  endtask

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = '0;
    if (rst) return r;
    if (m_owner >= 0) begin
      if (req_valid[m_owner]) r[m_owner] = 1'b1;
      return r;
    end
    for (int n = 0; n < 4; n++) begin
      if (req_valid[(m_rr + n) % 4]) begin
        r[(m_rr + n) % 4] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q = '0; m_rr = 0; m_owner = -1; m_idle = 0; m_gid = 0;
  endtask

  task automatic model_advance();
    logic [3:0] r;
    int w, ix;
    logic [1:0] jk;
    r = model_ready();
    w = -1;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) if (r[i]) w = i;
    if (w >= 0) begin
      ix = int'(req_idx[w*3 +: 3]);
      jk = req_jk[w*2 +: 2];
      if (jk == 2'b01) m_q[ix] = 1'b0;
      else if (jk == 2'b10) m_q[ix] = 1'b1;
      else if (jk == 2'b11) m_q[ix] = ~m_q[ix];
      m_gid  = w;
      m_idle = 0;
      if (m_owner < 0) begin
        m_rr = (w + 1) % 4;
        if (req_lock[w]) m_owner = w;
      end else if (!req_lock[w]) begin
        m_rr    = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end else if (m_owner >= 0) begin
      m_idle++;
      if (m_idle == 15) begin
        m_rr    = (m_owner + 1) % 4;
        m_owner = -1;
        m_idle  = 0;
      end
    end
  endtask

  // One clock: check every output against the model mid-cycle, then advance it.
  task automatic step(output logic [3:0] seen);
    logic [7:0] qb_exp;
    @(negedge clk);
    seen   = req_ready;
    qb_exp = ~m_q;
    checkOutput("ready", req_ready, model_ready());
    checkOutput("q", q, m_q);
    checkOutput("qb", qb, qb_exp);
    checkOutput("grant_id", grant_id, m_gid);
    checkOutput("locked", locked, m_owner >= 0);
    checkOutput("err", err, 0);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seen;
    logic [7:0] qb_exp;

    vecs[0]  = mk(0, 4'b0001, 12'o0003, 8'b00000010, 4'b0001, 8'h08, 2'd0, 0);
    vecs[1]  = mk(0, 4'b0001, 12'o0003, 8'b00000011, 4'b0001, 8'h00, 2'd0, 0);
    vecs[2]  = mk(0, 4'b0001, 12'o0003, 8'b00000011, 4'b0001, 8'h08, 2'd0, 0);
    vecs[3]  = mk(0, 4'b0001, 12'o0003, 8'b00000000, 4'b0001, 8'h08, 2'd0, 0);
    vecs[4]  = mk(1, 4'b0000, 12'o0000, 8'b00000000, 4'b0000, 8'h00, 2'd0, 0);
    vecs[5]  = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b0001, 8'h10, 2'd0, 0);
    vecs[6]  = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b0010, 8'h30, 2'd1, 0);
    vecs[7]  = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b0100, 8'h70, 2'd2, 0);
    vecs[8]  = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b1000, 8'hF0, 2'd3, 0);
    vecs[9]  = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b0001, 8'hF0, 2'd0, 0);
    vecs[10] = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b0010, 8'hF0, 2'd1, 0);
    vecs[11] = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b0100, 8'hF0, 2'd2, 0);
    vecs[12] = mk(0, 4'b1111, 12'o7654, 8'b10101010, 4'b1000, 8'hF0, 2'd3, 0);

    rst = 1'b1;
    clearReqs();
    d6_valid = '0; d6_idx = '0; d6_jk = '0; d6_lock = '0;
    model_reset();

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", req_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("reset_q", q, 8'h00);
    checkOutput("reset_qb", qb, 8'hFF);
    checkOutput("reset_gid", grant_id, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_err", err, 0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v]);
      step(seen);
      qb_exp = ~vecs[v].exp_q;
      checkOutput($sformatf("vec%0d_ready", v), seen, vecs[v].exp_ready);
      checkOutput($sformatf("vec%0d_q", v), q, vecs[v].exp_q);
      checkOutput($sformatf("vec%0d_qb", v), qb, qb_exp);
      checkOutput($sformatf("vec%0d_gid", v), grant_id, vecs[v].exp_gid);
      checkOutput($sformatf("vec%0d_locked", v), locked, vecs[v].exp_locked);
    end

    // Requester 2 locks, then goes quiet while the others wait out the timeout.
    clearReqs();
    setReq(2, 1, 3'd0, 2'b10, 1);
    step(seen);
    checkOutput("lock_grant", seen, 4'b0100);
    checkOutput("lock_locked", locked, 1);
    clearReqs();
    setReq(0, 1, 3'd1, 2'b10, 0);
    setReq(1, 1, 3'd1, 2'b10, 0);
    setReq(3, 1, 3'd1, 2'b10, 0);
    for (int c = 1; c <= 15; c++) begin
      step(seen);
      checkOutput($sformatf("stall%0d_ready", c), seen, 4'b0000);
      checkOutput($sformatf("stall%0d_locked", c), locked, c < 15);
    end
    step(seen);
    checkOutput("after_timeout_grant", seen, 4'b1000);
    checkOutput("after_timeout_q", q, 8'hF3);

    // Three-beat locked sequence from requester 1, then release.
    clearReqs();
    setReq(1, 1, 3'd2, 2'b10, 1);
    step(seen);
    checkOutput("beat1_ready", seen, 4'b0010);
    checkOutput("beat1_q", q, 8'hF7);
    setReq(1, 1, 3'd2, 2'b01, 1);
    step(seen);
    checkOutput("beat2_q", q, 8'hF3);
    checkOutput("beat2_locked", locked, 1);
    setReq(1, 1, 3'd2, 2'b11, 0);
    step(seen);
    checkOutput("beat3_q", q, 8'hF7);
    checkOutput("beat3_locked", locked, 0);
    setReq(0, 1, 3'd0, 2'b00, 0);
    setReq(1, 1, 3'd0, 2'b00, 0);
    setReq(2, 1, 3'd0, 2'b00, 1);
    setReq(3, 1, 3'd0, 2'b00, 0);
    step(seen);
    checkOutput("release_rr_grant", seen, 4'b0100);
    checkOutput("relock_locked", locked, 1);
    rst = 1'b1;
    step(seen);
    checkOutput("midlock_rst_ready", seen, 4'b0000);
    checkOutput("midlock_rst_q", q, 8'h00);
    checkOutput("midlock_rst_locked", locked, 0);
    rst = 1'b0;
    clearReqs();

    // Random traffic with held commands until accepted.
    for (int i = 0; i < 4; i++) begin
      p_v[i] = 1'b0; p_idx[i] = '0; p_jk[i] = '0; p_lk[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!p_v[i] && ($urandom_range(0, 2) == 0)) begin
          p_v[i]   = 1'b1;
          p_idx[i] = 3'($urandom_range(0, 7));
          p_jk[i]  = 2'($urandom_range(0, 3));
          p_lk[i]  = ($urandom_range(0, 4) == 0);
        end
        setReq(i, p_v[i], p_idx[i], p_jk[i], p_lk[i]);
      end
      step(seen);
      for (int i = 0; i < 4; i++) if (seen[i] && p_v[i]) p_v[i] = 1'b0;
    end
    clearReqs();

    // Six-cell instance: in-range set, then an out-of-range beat.
    d6_valid = 4'b0001; d6_idx = 12'o0005; d6_jk = 8'b00000010;
    @(negedge clk);
    checkOutput("d6_inrange_ready", d6_ready, 4'b0001);
    @(posedge clk);
    #1;
    checkOutput("d6_inrange_q", d6_q, 6'h20);
    checkOutput("d6_inrange_err", d6_err, 0);
    d6_idx = 12'o0007;
    @(negedge clk);
    checkOutput("d6_oor_ready", d6_ready, 4'b0001);
    @(posedge clk);
    #1;
    checkOutput("d6_oor_q", d6_q, 6'h20);
    checkOutput("d6_oor_err", d6_err, ERR_EXP);
    d6_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("d6_sticky_err", d6_err, ERR_EXP);
    checkOutput("d6_sticky_q", d6_q, 6'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
